memory_responder: RTL and testbench
===================================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter MASTER_ID_WIDTH, default 8, sets the request/response tag width.
REQ-002 Parameter ADDRESS_WIDTH, default 32, sets the request address width.
REQ-003 Parameter DATA_WIDTH, default 24, sets the word width.
REQ-004 Parameter DEPTH_LOG2, default 12, gives the backing store size of 2^DEPTH_LOG2 words.
REQ-005 Parameter READ_LATENCY, default 2, range 1-4, sets the store read pipeline depth.
REQ-006 Parameter RESP_DEPTH, default 4, power of 2 and at least 2, sets the number of response FIFO entries.
REQ-007 One clock; reset is asynchronous and active-high; ports are named clock and reset.
REQ-008 Port list (name, direction, width, meaning):
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous active-high reset.
- mValid  in  1  request valid.
- mReady  out  1  request accepted this cycle if mValid.
- mWrite  in  1  1=write, 0=read.
- mAddress  in  ADDRESS_WIDTH  word address.
- mData  in  DATA_WIDTH  write data.
- mId  in  MASTER_ID_WIDTH  requester tag.
- sValid  out  1  response valid.
- sReady  in  1  response consumed this cycle if sValid.
- sData  out  DATA_WIDTH  read data.
- sId  out  MASTER_ID_WIDTH  tag echoed from the request.

Function
REQ-009 The block SHALL accept a request on a clock edge where mValid and mReady are both high.
REQ-010 For an accepted write, the block SHALL store mData at mAddress[DEPTH_LOG2-1:0] on the accept edge and SHALL produce no response.
REQ-011 An accepted read SHALL enter a READ_LATENCY-stage pipeline carrying mId, then be pushed into the response FIFO.
REQ-012 With the FIFO empty and sReady high, a read accepted in cycle N SHALL present sValid in cycle N+READ_LATENCY+1.
REQ-013 Responses SHALL leave in request-acceptance order.
REQ-014 The block SHALL compute mReady = (RESP_DEPTH - fifoCount - inFlight) > 0, registered-free, so that no read is ever dropped.
REQ-015 The fifoCount term in REQ-014 SHALL NOT include credit freed by a pop in the same cycle.
REQ-016 An out-of-range address (any bit above DEPTH_LOG2-1 set) SHALL make a write a no-op and SHALL make a read return sData=0 with the correct sId.
REQ-017 A read accepted the cycle after a write to the same address SHALL return the new data.
REQ-018 sData and sId SHALL be held stable while sValid is high and sReady is low.
REQ-019 A simultaneous FIFO push and pop SHALL leave the FIFO count unchanged.
REQ-020 A simultaneous push and pop on an empty FIFO SHALL NOT bypass the FIFO.

Reset
REQ-021 While reset is high, the block SHALL hold mReady=0, sValid=0, sData=0 and sId=0.
REQ-022 Reset SHALL clear the FIFO pointers, the pipeline valid bits and the in-flight count.
REQ-023 Reset SHALL NOT clear store contents.
REQ-024 mReady SHALL rise on the first edge after reset deasserts.
REQ-025 Reset asserted mid-operation SHALL discard in-flight reads without emitting responses.

Configuration
REQ-026 With MEMORY_RESPONDER_WRITE_ACK_EN defined, accepted writes SHALL consume a credit and return a response with sData = the written data and sId = mId, in order with reads.
REQ-027 With MEMORY_RESPONDER_WRITE_ACK_EN defined, out-of-range writes SHALL still be acknowledged, with sData=0.
REQ-028 Without MEMORY_RESPONDER_WRITE_ACK_EN, writes SHALL produce no response and SHALL consume no credit.

Structure
REQ-029 MemoryPkg SHALL hold the default width constants and a response struct {data, id}.
REQ-030 The response FIFO SHALL be a sub-module named sync_fifo, parameterised by width and depth, exposing count.
REQ-031 The store SHALL be a single inferred block RAM.

Verification
REQ-032 Bench: write 0xABCDEF to address 5, then read 5 with id 3 the next cycle -> sData=0xABCDEF, sId=3, sValid in cycle accept+3.
REQ-033 Bench: hold sReady=0 and issue 4 reads -> mReady=0 after the 4th accept; raise sReady -> 4 responses in order, then mReady=1.
REQ-034 Bench: read address 0x1000 (DEPTH_LOG2=12) with id 7 -> sData=0, sId=7.
REQ-035 Bench: assert reset with 2 reads in flight -> no response emitted; next read of a prior write returns stored data.
REQ-036 Bench: back-to-back reads with ids 1,2,3 and sReady toggling every cycle -> ids returned 1,2,3 with data stable while stalled.
REQ-037 Bench: with MEMORY_RESPONDER_WRITE_ACK_EN, write 0x000011 with id 9 -> response sData=0x000011, sId=9.

Source files
------------

// File: rtl/memory_responder_pkg.sv
// Shared defaults and the response record for memory_responder.
// The optional write-acknowledge mode is selected by MEMORY_RESPONDER_WRITE_ACK_EN.
package MemoryPkg;

  localparam int unsigned DEF_MASTER_ID_WIDTH = 8;
  localparam int unsigned DEF_ADDRESS_WIDTH   = 32;
  localparam int unsigned DEF_DATA_WIDTH      = 24;
  localparam int unsigned DEF_DEPTH_LOG2      = 12;
  localparam int unsigned DEF_READ_LATENCY    = 2;
  localparam int unsigned DEF_RESP_DEPTH      = 4;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0]      data;
    logic [DEF_MASTER_ID_WIDTH-1:0] id;
  } resp_t;

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/memory_responder_fifo.sv
// sync_fifo: power-of-two response queue with registered storage and occupancy count.
// A push is never visible at the output in the same cycle, even when the queue is empty.
module sync_fifo #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [AW:0]      count_o,
  output logic             empty_o
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PTR_ONE;
    if (do_pop)  rptr_d = rptr_q + PTR_ONE;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
  end

  assign pop_data_o = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/memory_responder.sv
// memory_responder: word-addressed store answering tagged reads in order through a response FIFO.
// Define MEMORY_RESPONDER_WRITE_ACK_EN to make writes return an in-order acknowledge response.
module memory_responder
  import MemoryPkg::*;
#(
  parameter int unsigned MASTER_ID_WIDTH = DEF_MASTER_ID_WIDTH,
  parameter int unsigned ADDRESS_WIDTH   = DEF_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH_LOG2      = DEF_DEPTH_LOG2,
  parameter int unsigned READ_LATENCY    = DEF_READ_LATENCY,
  parameter int unsigned RESP_DEPTH      = DEF_RESP_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       mValid,
  output logic                       mReady,
  input  logic                       mWrite,
  input  logic [ADDRESS_WIDTH-1:0]   mAddress,
  input  logic [DATA_WIDTH-1:0]      mData,
  input  logic [MASTER_ID_WIDTH-1:0] mId,
  output logic                       sValid,
  input  logic                       sReady,
  output logic [DATA_WIDTH-1:0]      sData,
  output logic [MASTER_ID_WIDTH-1:0] sId
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and the response side holds data while stalled.

  localparam int unsigned CW    = count_width(RESP_DEPTH);
  localparam int unsigned RW    = DATA_WIDTH + MASTER_ID_WIDTH;
  localparam int unsigned WORDS = 1 << DEPTH_LOG2;
  localparam logic [CW:0]   CREDITS = RESP_DEPTH[CW:0];
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic                       accept;
  logic                       rd_accept;
  logic                       resp_req;
  logic                       oor;
  logic [DEPTH_LOG2-1:0]      word_idx;

  assign word_idx  = mAddress[DEPTH_LOG2-1:0];
  assign accept    = mValid && mReady;
  assign rd_accept = accept && !mWrite;

  generate
    if (ADDRESS_WIDTH > DEPTH_LOG2) begin : g_oor
      assign oor = |mAddress[ADDRESS_WIDTH-1:DEPTH_LOG2];
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
  endgenerate

`ifdef MEMORY_RESPONDER_WRITE_ACK_EN
  assign resp_req = accept;
`else
  assign resp_req = rd_accept;
`endif

  // Backing store: one write port, one registered read port, no reset.
  logic [DATA_WIDTH-1:0] store_q [WORDS];
  logic [DATA_WIDTH-1:0] store_rdata_q;

  always_ff @(posedge clock) begin
    if (accept && mWrite && !oor) store_q[word_idx] <= mData;
    if (rd_accept)                store_rdata_q     <= store_q[word_idx];
  end

  // Stage 0 sits alongside the store read register.
  logic                       s0_valid_q;
  logic [MASTER_ID_WIDTH-1:0] s0_id_q;
  logic                       s0_oor_q;
  logic [DATA_WIDTH-1:0]      s0_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s0_valid_q <= 1'b0;
      s0_id_q    <= '0;
      s0_oor_q   <= 1'b0;
    end else begin
      s0_valid_q <= resp_req;
      if (resp_req) begin
        s0_id_q  <= mId;
        s0_oor_q <= oor;
      end
    end
  end

`ifdef MEMORY_RESPONDER_WRITE_ACK_EN
  logic                  s0_wr_q;
  logic [DATA_WIDTH-1:0] s0_wdata_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s0_wr_q    <= 1'b0;
      s0_wdata_q <= '0;
    end else if (resp_req) begin
      s0_wr_q    <= mWrite;
      s0_wdata_q <= mData;
    end
  end

  assign s0_data = s0_oor_q ? '0 : (s0_wr_q ? s0_wdata_q : store_rdata_q);
`else
  assign s0_data = s0_oor_q ? '0 : store_rdata_q;
`endif

  logic                       push_valid;
  logic [DATA_WIDTH-1:0]      push_data;
  logic [MASTER_ID_WIDTH-1:0] push_id;

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign push_valid = s0_valid_q;
      assign push_data  = s0_data;
      assign push_id    = s0_id_q;
    end else begin : g_pipe
      localparam int unsigned NS = READ_LATENCY - 1;
      logic [NS-1:0]              pv_q;
      logic [MASTER_ID_WIDTH-1:0] pid_q [NS];
      logic [DATA_WIDTH-1:0]      pd_q  [NS];

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          pv_q <= '0;
          for (int k = 0; k < NS; k++) begin
            pid_q[k] <= '0;
            pd_q[k]  <= '0;
          end
        end else begin
          pv_q[0]  <= s0_valid_q;
          pid_q[0] <= s0_id_q;
          pd_q[0]  <= s0_data;
          for (int k = 1; k < NS; k++) begin
            pv_q[k]  <= pv_q[k-1];
            pid_q[k] <= pid_q[k-1];
            pd_q[k]  <= pd_q[k-1];
          end
        end
      end

      assign push_valid = pv_q[NS-1];
      assign push_data  = pd_q[NS-1];
      assign push_id    = pid_q[NS-1];
    end
  endgenerate

  // Credits: every accepted response-producing request reserves a FIFO slot up front.
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   used;
  logic          ready_en_q;

  always_comb begin
    inflight_d = inflight_q;
    case ({resp_req, push_valid})
      2'b10:   inflight_d = inflight_q + CNT_ONE;
      2'b01:   inflight_d = inflight_q - CNT_ONE;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight_q <= '0;
      ready_en_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      ready_en_q <= 1'b1;
    end
  end

  // fifo_count is the pre-pop occupancy, so a same-cycle pop frees no credit yet.
  assign used   = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign mReady = ready_en_q && (used < CREDITS);

  logic          fifo_empty;
  logic          pop;
  logic [RW-1:0] fifo_rdata;

  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clock_i     (clock),
    .reset_i     (reset),
    .push_i      (push_valid),
    .push_data_i ({push_data, push_id}),
    .pop_i       (pop),
    .pop_data_o  (fifo_rdata),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign sValid = !fifo_empty;
  assign pop    = sValid && sReady;
  assign sData  = sValid ? fifo_rdata[RW-1:MASTER_ID_WIDTH] : '0;
  assign sId    = sValid ? fifo_rdata[MASTER_ID_WIDTH-1:0]  : '0;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: directed table, multi-cycle corner sequences and random traffic
// checked against an ordered-response model of the store.
module tb_memory_responder;
  import MemoryPkg::*;

  localparam int unsigned IW = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 24;
  localparam int unsigned DL = 12;
  localparam int unsigned RL = 2;
  localparam int unsigned RD = 4;
  localparam int unsigned RW = IW + DW;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          mValid = 1'b0;
  logic          mReady;
  logic          mWrite = 1'b0;
  logic [AW-1:0] mAddress = '0;
  logic [DW-1:0] mData = '0;
  logic [IW-1:0] mId = '0;
  logic          sValid;
  logic          sReady = 1'b0;
  logic [DW-1:0] sData;
  logic [IW-1:0] sId;

  always #5 clock = ~clock;

  memory_responder #(
    .MASTER_ID_WIDTH (IW),
    .ADDRESS_WIDTH   (AW),
    .DATA_WIDTH      (DW),
    .DEPTH_LOG2      (DL),
    .READ_LATENCY    (RL),
    .RESP_DEPTH      (RD)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .mValid   (mValid),
    .mReady   (mReady),
    .mWrite   (mWrite),
    .mAddress (mAddress),
    .mData    (mData),
    .mId      (mId),
    .sValid   (sValid),
    .sReady   (sReady),
    .sData    (sData),
    .sId      (sId)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] model_mem [1 << DL];
  logic [RW-1:0] exp_q [$];
  logic [IW-1:0] pop_log [$];
  logic          chk_ready = 1'b0;
  logic          stall_vld = 1'b0;
  logic [RW-1:0] stall_val = '0;

  function automatic logic in_range(input logic [AW-1:0] a);
    return (a >> DL) == 0;
  endfunction

  function automatic logic [DW-1:0] init_word(input int i);
    return DW'(32'h3C0000 + i * 32'h010203);
  endfunction

  always @(negedge clock) begin : monitor
    logic [DW-1:0] d;
    logic [RW-1:0] e;
    if (reset) begin
      exp_q.delete();
      stall_vld = 1'b0;
      chk_ready = 1'b0;
    end else begin
      if (chk_ready) check("mready_credit", mReady, (exp_q.size() < RD) ? 1 : 0);
      if (mValid && mReady) begin
        if (mWrite) begin
          if (in_range(mAddress)) model_mem[mAddress[DL-1:0]] = mData;
`ifdef MEMORY_RESPONDER_WRITE_ACK_EN
          d = in_range(mAddress) ? mData : {DW{1'b0}};
          exp_q.push_back({mId, d});
`endif
        end else begin
          d = in_range(mAddress) ? model_mem[mAddress[DL-1:0]] : {DW{1'b0}};
          exp_q.push_back({mId, d});
        end
      end
      if (sValid) begin
        if (stall_vld) check("stall_hold", {sId, sData}, stall_val);
        if (sReady) begin
          pop_log.push_back(sId);
          stall_vld = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_resp", {sId, sData}, 32'hDEAD_BEEF ^ {sId, sData} ^ 32'hDEAD_BEEF ^ 32'h1);
          end else begin
            e = exp_q.pop_front();
            check("resp_order", {sId, sData}, e);
          end
        end else begin
          stall_vld = 1'b1;
          stall_val = {sId, sData};
        end
      end else begin
        if (stall_vld) check("svalid_hold", sValid, 1);
        stall_vld = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [IW-1:0] id, output int unsigned acc);
    int unsigned n = 0;
    mValid = 1'b1; mWrite = wr; mAddress = a; mData = d; mId = id;
    @(negedge clock);
    while (!mReady && n < 100) begin
      @(negedge clock);
      n++;
    end
    acc = cyc;
    if (!mReady) fail("req_accept");
    @(posedge clock); #1;
    mValid = 1'b0;
  endtask

  task automatic wait_valid(output int unsigned c);
    int unsigned n = 0;
    @(negedge clock);
    while (!sValid && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (!sValid) fail("resp_wait");
    c = cyc;
  endtask

  task automatic wait_pops(input int unsigned want, input string name);
    int unsigned n = 0;
    while (pop_log.size() < want && n < 80) begin
      @(negedge clock);
      n++;
    end
    if (pop_log.size() < want) fail(name);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_mready", mReady, 0);
    check("rst_svalid", sValid, 0);
    check("rst_sdata", sData, 0);
    check("rst_sid", sId, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("mready_before_edge", mReady, 0);
    @(negedge clock);
    check("mready_after_edge", mReady, 1);
    chk_ready = 1'b1;
    @(posedge clock); #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          wr_first;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [IW-1:0] id;
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] exp_ack;
  } vec_t;

  vec_t vecs [8];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned acc, vc, seen;
    logic        last_acc;

    vecs[0] = '{1'b1, 32'h0000_0005, 24'hABCDEF, 8'h03, 24'hABCDEF, 24'hABCDEF};
    vecs[1] = '{1'b0, 32'h0000_1000, 24'h000000, 8'h07, 24'h000000, 24'h000000};
    vecs[2] = '{1'b1, 32'h0000_0FFF, 24'h5A5A5A, 8'hFF, 24'h5A5A5A, 24'h5A5A5A};
    vecs[3] = '{1'b1, 32'h0000_1005, 24'h111111, 8'h04, 24'h000000, 24'h000000};
    vecs[4] = '{1'b0, 32'h0000_0005, 24'h000000, 8'h08, 24'hABCDEF, 24'h000000};
    vecs[5] = '{1'b1, 32'h0000_0000, 24'h000001, 8'h00, 24'h000001, 24'h000001};
    vecs[6] = '{1'b1, 32'h8000_0005, 24'h222222, 8'h12, 24'h000000, 24'h000000};
    vecs[7] = '{1'b0, 32'h0000_0005, 24'h000000, 8'h13, 24'hABCDEF, 24'h000000};

    apply_reset();

    // Preload the addresses random traffic will use.
    sReady = 1'b1;
    for (int i = 0; i < 16; i++) do_req(1'b1, AW'(i), init_word(i), IW'(i), acc);
    repeat (10) @(posedge clock);
    #1;

    // Write then read the next cycle, or read alone; check latency, data, tag.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr_first) do_req(1'b1, vecs[i].addr, vecs[i].wdata, vecs[i].id ^ 8'h80, acc);
      do_req(1'b0, vecs[i].addr, '0, vecs[i].id, acc);
`ifdef MEMORY_RESPONDER_WRITE_ACK_EN
      if (vecs[i].wr_first) begin
        wait_valid(vc);
        check("tbl_ack_data", sData, vecs[i].exp_ack);
        check("tbl_ack_id", sId, vecs[i].id ^ 8'h80);
        @(posedge clock); #1;
      end
`endif
      wait_valid(vc);
      check("tbl_latency", vc, acc + RL + 1);
      check("tbl_rdata", sData, vecs[i].exp_rdata);
      check("tbl_id", sId, vecs[i].id);
      @(posedge clock); #1;
    end

    // Credit exhaustion with the consumer stalled, then in-order drain.
    sReady = 1'b0;
    for (int k = 0; k < 4; k++) do_req(1'b0, AW'(k + 1), '0, IW'(8'h20 + k), acc);
    @(negedge clock);
    check("credit_exhausted", mReady, 0);
    @(posedge clock); #1;
    pop_log.delete();
    sReady = 1'b1;
    wait_pops(4, "credit_drain");
    for (int k = 0; k < 4; k++) begin
      if (k < pop_log.size()) check("credit_order", pop_log[k], 8'h20 + k);
    end
    @(posedge clock);
    @(negedge clock);
    check("credit_restored", mReady, 1);
    @(posedge clock); #1;

    // Back-to-back reads while the consumer toggles ready every cycle.
    pop_log.delete();
    sReady = 1'b0;
    fork
      begin
        do_req(1'b0, 32'h5, '0, 8'h01, acc);
        do_req(1'b0, 32'h0, '0, 8'h02, acc);
        do_req(1'b0, 32'hFFF, '0, 8'h03, acc);
      end
      begin
        for (int k = 0; k < 24; k++) begin
          sReady = ~sReady;
          @(posedge clock); #1;
        end
      end
    join
    sReady = 1'b1;
    wait_pops(3, "toggle_drain");
    for (int k = 0; k < 3; k++) begin
      if (k < pop_log.size()) check("toggle_order", pop_log[k], k + 1);
    end
    @(posedge clock); #1;

`ifdef MEMORY_RESPONDER_WRITE_ACK_EN
    do_req(1'b1, 32'h20, 24'h000011, 8'h09, acc);
    wait_valid(vc);
    check("wack_latency", vc, acc + RL + 1);
    check("wack_data", sData, 24'h000011);
    check("wack_id", sId, 8'h09);
    @(posedge clock); #1;
`endif

    // Reset with two reads in flight: nothing may emerge, store survives.
    sReady = 1'b1;
    do_req(1'b0, 32'h9, '0, 8'h41, acc);
    do_req(1'b0, 32'h9, '0, 8'h42, acc);
    apply_reset();
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (sValid) seen++;
    end
    check("no_resp_after_reset", seen, 0);
    @(posedge clock); #1;
    do_req(1'b0, 32'h9, '0, 8'h43, acc);
    wait_valid(vc);
    check("post_reset_data", sData, init_word(9));
    check("post_reset_id", sId, 8'h43);
    @(posedge clock); #1;

    // Random traffic against the model.
    last_acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!mValid || last_acc) begin
        mValid = ($urandom_range(0, 3) != 0);
        mWrite = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 7) == 0)
          mAddress = (32'h1000 << $urandom_range(0, 19)) | 32'($urandom_range(0, 15));
        else
          mAddress = 32'($urandom_range(0, 15));
        mData = DW'($urandom());
        mId   = IW'($urandom());
      end
      sReady = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      last_acc = mValid && mReady;
      @(posedge clock); #1;
    end
    mValid = 1'b0;
    sReady = 1'b1;
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) @(posedge clock);
    check("drain_empty", exp_q.size(), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("idle_svalid", sValid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
